fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request feeding a DEPTH-entry buffer; redirects flush it.
// A transfer in cycle N is visible at instr in N+1; decode stalls via instr_ready and fetch stops when no slot is free.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          DEPTH          = 2,
  parameter bit          MEM_BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     buf_instr [DEPTH];
  logic [31:0]     buf_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            transfer;
  logic            pop;
  logic            push;
  logic [31:0]     fetch_word;
  logic [31:0]     redirect_target;
  logic [31:0]     next_fetch_pc;
  logic [CW-1:0]   count_after_pop;
  logic [CW-1:0]   count_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign transfer        = imem_req & imem_ack;
  assign pop             = instr_valid & instr_ready;
  // Data landing in DISCARD, or together with a redirect, belongs to the old path.
  assign push            = transfer & (state == WAIT) & ~redirect_valid;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign next_fetch_pc   = fetch_pc + 32'd4;
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);

  generate
    if (MEM_BIG_ENDIAN) begin : g_swap
      assign fetch_word = {imem_rdata[7:0], imem_rdata[15:8], imem_rdata[23:16], imem_rdata[31:24]};
    end else begin : g_noswap
      assign fetch_word = imem_rdata;
    end
  endgenerate

  assign instr_valid = (count != '0);
  assign instr       = buf_instr[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  // Request sequencer; the in-flight request always owns one buffer slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end else if (count_after_pop < DEPTH_C) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (transfer) begin
            if (redirect_valid) begin
              fetch_pc <= redirect_target;
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              fetch_pc <= next_fetch_pc;
              if (count_next < DEPTH_C) begin
                imem_addr <= next_fetch_pc;
              end else begin
                state    <= IDLE;
                imem_req <= 1'b0;
              end
            end
          end else if (redirect_valid) begin
            // Old request must still complete at its original address.
            fetch_pc <= redirect_target;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
          end
          if (transfer) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Instruction buffer: circular FIFO, flushed outright by any redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= fetch_word;
        buf_pc[wr_ptr]    <= imem_addr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against an in-order PC/word scoreboard.
module tb_fetch_unit;

  localparam int DEPTH_M = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        w_one  = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zpc  = 32'd0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1122_3344;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign w_imem_rdata = mem_word(w_imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH_M), .MEM_BIG_ENDIAN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .MEM_BIG_ENDIAN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_one),
    .imem_rdata(w_imem_rdata), .redirect_valid(w_zero), .redirect_pc(w_zpc),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(w_one)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: delivered instructions are the contiguous PC stream starting at the
  // reset PC or the latest redirect target, each carrying the byte-swapped memory word.
  logic [31:0] exp_pc;
  logic        prev_hold, prev_stall, prev_redir;
  logic [31:0] prev_addr, prev_instr, prev_ipc;
  int          pops;

  task automatic model_clear();
    exp_pc     = 32'h0000_0000;
    prev_hold  = 1'b0;
    prev_stall = 1'b0;
    prev_redir = 1'b0;
  endtask

  // Called at a falling edge once this cycle's inputs are set; advances to the next falling edge.
  task automatic step();
    imem_rdata = mem_word(imem_addr);
    if (!rst) begin
      if (prev_hold) check32("addr_hold", imem_addr, prev_addr);
      if (prev_redir) begin
        check32("flush_valid", 32'(instr_valid), 32'd0);
      end else if (prev_stall) begin
        check32("stall_valid", 32'(instr_valid), 32'd1);
        check32("stall_instr", instr, prev_instr);
        check32("stall_pc", instr_pc, prev_ipc);
      end
      if (imem_req) check32("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
        check32("pop_pc", instr_pc, exp_pc);
        check32("pop_instr", instr, bswap(mem_word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instr;
      prev_ipc   = instr_pc;
      prev_redir = redirect_valid;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_ack       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] wseq [3];
    int n;
    int xfers;
    wseq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    pops = 0;
    model_clear();
    rst            = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 32'd0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(negedge clk);

    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_addr", imem_addr, 32'd0);
    check32("rst_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_ipc", instr_pc, 32'd0);
    check32("rst_waddr", w_imem_addr, 32'hFFFF_FFF8);

    // Zero-wait streaming: first request one cycle after release, then one instruction per cycle.
    rst = 1'b0;
    model_clear();
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) check32("req_at_release", 32'(imem_req), 32'd0);
      if (i == 1) check32("first_req", 32'(imem_req), 32'd1);
      if (i >= 2) check32("stream_valid", 32'(instr_valid), 32'd1);
      if (i >= 1 && i <= 3) check32("wrap_addr", w_imem_addr, wseq[i-1]);
      if (i >= 2 && i <= 4) begin
        check32("wrap_ipc", w_instr_pc, wseq[i-2]);
        check32("wrap_instr", w_instr, mem_word(wseq[i-2]));
      end
      step();
    end

    // Decode stall: buffer fills to DEPTH, fetch stops, then drains without loss.
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    repeat (10) step();
    check32("full_req_low", 32'(imem_req), 32'd0);
    check32("full_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    imem_ack    = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!instr_valid) break;
      n++;
      step();
    end
    check32("drain_count", 32'(n), 32'(DEPTH_M));
    imem_ack = 1'b1;
    repeat (10) step();

    // Redirect during a slow transaction: old data dropped, next fetch at aligned target.
    do_reset();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    check32("slow_req", 32'(imem_req), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    step();
    check32("discard_addr_held", imem_addr, 32'd0);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) break;
      step();
    end
    check32("redir_req", 32'(imem_req), 32'd1);
    check32("redir_addr", imem_addr, 32'h0000_0100);
    imem_ack = 1'b1;
    repeat (8) step();

    // Redirect together with ack and pop while two entries are buffered.
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    xfers = 0;
    for (int i = 0; i < 10 && xfers < 2; i++) begin
      if (imem_req && imem_ack) xfers++;
      step();
    end
    imem_ack = 1'b0;
    step();
    check32("pre_redir_req", 32'(imem_req), 32'd1);
    check32("pre_redir_valid", 32'(instr_valid), 32'd1);
    imem_ack       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      step();
    end
    check32("post_redir_valid", 32'(instr_valid), 32'd1);
    check32("post_redir_ipc", instr_pc, 32'h0000_0200);
    repeat (5) step();

    // Asynchronous reset with an ack pending, then a late ack after release.
    do_reset();
    imem_ack    = 1'b1;
    instr_ready = 1'b0;
    repeat (3) step();
    imem_ack = 1'b0;
    repeat (2) step();
    check32("pend_req", 32'(imem_req), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check32("arst_req", 32'(imem_req), 32'd0);
    check32("arst_addr", imem_addr, 32'd0);
    check32("arst_valid", 32'(instr_valid), 32'd0);
    check32("arst_instr", instr, 32'd0);
    check32("arst_ipc", instr_pc, 32'd0);
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    instr_ready = 1'b1;
    step();
    check32("late_ack_valid", 32'(instr_valid), 32'd0);
    check32("late_ack_req", 32'(imem_req), 32'd1);
    repeat (8) step();

    // Random traffic against the scoreboard.
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_ack       = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                    : 32'($urandom);
      step();
    end
    check32("random_progress", 32'(pops > 500), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
